fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side controller of the async FIFO, sitting directly downstream of the read-to-write pointer synchronizer.
- Maintains the binary and Gray write pointers.
- Generates the RAM write address and enable.
- Compares the write pointer against the synchronized Gray read pointer to produce registered full, almost-full, fill level and a sticky overflow flag, all in the wrclk domain.
- Its Gray pointer output feeds the write-to-read synchronizer.

Parameters:
FIFO_ADDR_WIDTH, 8, RAM address width; depth = 2**FIFO_ADDR_WIDTH; pointers are FIFO_ADDR_WIDTH+1 bits; legal range >= 2
AFULL_THRESH, 2**FIFO_ADDR_WIDTH-4, wr_almost_full asserts when fill level >= this value; legal range 1..2**FIFO_ADDR_WIDTH

Ports:
wrclk  input  1  write-domain clock, all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request from producer
wrq2_rdptr  input  FIFO_ADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into wrclk
ovf_clr  input  1  synchronous clear of wr_overflow
wraddr  output  FIFO_ADDR_WIDTH  RAM write address = wrbin[FIFO_ADDR_WIDTH-1:0]
wr_mem_en  output  1  RAM write enable, combinational = wr_en & ~wrfull
wrptr  output  FIFO_ADDR_WIDTH+1  registered Gray write pointer, to write-to-read synchronizer
wrfull  output  1  registered full flag
wr_almost_full  output  1  registered almost-full flag
wr_level  output  FIFO_ADDR_WIDTH+1  registered fill level, 0..2**FIFO_ADDR_WIDTH
wr_overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (asynchronous, reset_n=0): wrbin=0, wrptr=0, wrfull=0, wr_almost_full=0, wr_level=0, wr_overflow=0. Resulting outputs: wraddr=0; wr_mem_en=wr_en (not gated, since wrfull=0). Reset may assert mid-burst; all state clears immediately, with no partial-write recovery.
- accept = wr_en & ~wrfull. A write with wrfull=1 is dropped: the pointer holds and RAM is not written.
- Pointer next-state:
  - wrbin_next = wrbin + accept, modulo 2**(FIFO_ADDR_WIDTH+1); wraps naturally.
  - wrgray_next = (wrbin_next >> 1) ^ wrbin_next.
  - Each clock: wrbin <= wrbin_next, wrptr <= wrgray_next.
  - wrptr changes by exactly one bit per accepted write and never glitches (register output only).
- Full:
  - wrfull <= (wrgray_next == {~wrq2_rdptr[A:A-1], wrq2_rdptr[A-2:0]}), where A = FIFO_ADDR_WIDTH.
  - Asserts in the same clock edge as the write that fills the last slot, so there is zero-cycle latency for back-to-back writes.
  - Deasserts only once the synchronized read pointer advances: 2+ wrclk after the read. This is conservative by design.
- Level:
  - rdbin = Gray-to-binary of wrq2_rdptr, combinational XOR prefix from MSB.
  - wr_level <= (wrbin_next - rdbin) modulo 2**(A+1). The value is pessimistic (never under-reports occupancy).
- Almost full: wr_almost_full <= ((wrbin_next - rdbin) mod 2**(A+1)) >= AFULL_THRESH. It updates on the same edge as wr_level.
- Overflow:
  - Set when wr_en & wrfull; cleared when ovf_clr.
  - Set has priority over a simultaneous clear.
  - Holds otherwise.
- Simultaneous write and synchronized read advance in the same cycle: the level is unchanged, and full is evaluated on the new pointers.
- wrq2_rdptr jumping by more than one position (slow wrclk vs fast rdclk) is legal. Level and full must track it correctly, with no assumption of single steps.

Test Plan:
- Reset check: A=4, AFULL_THRESH=12. Hold reset_n=0, toggle wr_en -> wrptr=0, wrfull=0, wr_level=0, wr_overflow=0, wraddr=0.
- Fill: wrq2_rdptr=0, 16 consecutive wr_en cycles.
  - wraddr steps 0..15.
  - wrptr Gray sequence is 00000,00001,00011,...,11000 after the 16th write.
  - wr_almost_full rises after the 12th write; wrfull rises after the 16th; wr_level=16.
- Overflow: continue from full with wr_en=1 for 3 cycles.
  - wr_mem_en=0 and wrptr unchanged.
  - wr_overflow=1 stays set.
  - ovf_clr=1 with wr_en=0 -> 0.
  - ovf_clr and the overflow condition in the same cycle -> remains 1.
- Drain release: full state, then set wrq2_rdptr to Gray(4)=00110 -> next edge wrfull=0, wr_level=12, wr_almost_full=1. Gray(5)=00111 -> wr_level=11, wr_almost_full=0.
- Wrap-around: 40 writes with wrq2_rdptr tracking wrptr at a 2-cycle lag.
  - wrbin wraps through 31->0.
  - wr_level stays <= 3 and wrfull never asserts.
  - Gray Hamming distance is 1 per accepted write.
- Async reset mid-operation: assert reset_n=0 between edges at level 7 -> all outputs clear without a clock; first write after release goes to wraddr=0.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: producer handshake, synchronized read
// pointer in, RAM write port and status flags out.
interface fifo_wr_ctrl_if #(
  parameter int FIFO_ADDR_WIDTH = 8
);
  logic                       wr_en;
  logic [FIFO_ADDR_WIDTH:0]   wrq2_rdptr;
  logic                       ovf_clr;
  logic [FIFO_ADDR_WIDTH-1:0] wraddr;
  logic                       wr_mem_en;
  logic [FIFO_ADDR_WIDTH:0]   wrptr;
  logic                       wrfull;
  logic                       wr_almost_full;
  logic [FIFO_ADDR_WIDTH:0]   wr_level;
  logic                       wr_overflow;

  modport master (
    output wr_en, wrq2_rdptr, ovf_clr,
    input  wraddr, wr_mem_en, wrptr, wrfull, wr_almost_full, wr_level, wr_overflow
  );

  modport slave (
    input  wr_en, wrq2_rdptr, ovf_clr,
    output wraddr, wr_mem_en, wrptr, wrfull, wr_almost_full, wr_level, wr_overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointers, RAM write
// port, and registered full / almost-full / level / sticky overflow flags.
module fifo_wr_ctrl #(
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int AFULL_THRESH    = 2**FIFO_ADDR_WIDTH - 4
) (
  input logic          wrclk,
  input logic          reset_n,
  fifo_wr_ctrl_if.slave bus
);
  localparam int A = FIFO_ADDR_WIDTH;
  localparam logic [A:0] AFULL_LVL = AFULL_THRESH[A:0];

  logic [A:0] wrbin;
  logic [A:0] wrbin_next;
  logic [A:0] wrgray_next;
  logic [A:0] rdbin;
  logic [A:0] level_next;
  logic [A:0] wrptr_q;
  logic [A:0] level_q;
  logic       full_q;
  logic       afull_q;
  logic       ovf_q;
  logic       accept;
  logic       full_next;

  assign accept      = bus.wr_en & ~full_q;
  assign wrbin_next  = wrbin + {{A{1'b0}}, accept};
  assign wrgray_next = (wrbin_next >> 1) ^ wrbin_next;

  // Each binary bit is the XOR of all Gray bits at or above it, so a
  // multi-position jump of the read pointer decodes just as well as a step.
  always_comb begin
    rdbin = '0;
    for (int i = 0; i <= A; i++) begin
      rdbin[i] = ^(bus.wrq2_rdptr >> i);
    end
  end

  assign level_next = wrbin_next - rdbin;
  assign full_next  = (wrgray_next == {~bus.wrq2_rdptr[A:A-1], bus.wrq2_rdptr[A-2:0]});

  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      wrbin   <= '0;
      wrptr_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
    end else begin
      wrbin   <= wrbin_next;
      wrptr_q <= wrgray_next;
      full_q  <= full_next;
      afull_q <= (level_next >= AFULL_LVL);
      level_q <= level_next;
    end
  end

  // A dropped write in the same cycle as a clear still leaves the flag set.
  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en & full_q) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.wraddr         = wrbin[A-1:0];
  assign bus.wr_mem_en      = accept;
  assign bus.wrptr          = wrptr_q;
  assign bus.wrfull         = full_q;
  assign bus.wr_almost_full = afull_q;
  assign bus.wr_level       = level_q;
  assign bus.wr_overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (depth 16, almost-full at 12) with a
// count-based occupancy model checked every cycle plus literal spot checks.
module tb_fifo_wr_ctrl;
  localparam int A  = 4;
  localparam int TH = 12;

  logic wrclk   = 1'b0;
  logic reset_n = 1'b0;

  int checks   = 0;
  int passes   = 0;
  bit checking = 1'b0;

  int rd_pos = 0;
  int m_wr   = 0;
  int m_lvl  = 0;
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;

  fifo_wr_ctrl_if #(.FIFO_ADDR_WIDTH(A)) bus ();

  fifo_wr_ctrl #(.FIFO_ADDR_WIDTH(A), .AFULL_THRESH(TH)) dut (
    .wrclk   (wrclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 wrclk = ~wrclk;

  function automatic logic [A:0] gray(input int v);
    logic [A:0] b;
    b = v[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input int rdp);
    bus.wr_en      = en;
    bus.ovf_clr    = clr;
    rd_pos         = rdp;
    bus.wrq2_rdptr = gray(rdp);
    @(posedge wrclk);
    #2;
  endtask

  // Model: occupancy is simply accepted writes minus read position.
  always @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      m_wr = 0; m_lvl = 0; m_full = 1'b0; m_ovf = 1'b0;
    end else begin
      if (bus.wr_en && m_full) m_ovf = 1'b1;
      else if (bus.ovf_clr)    m_ovf = 1'b0;
      if (bus.wr_en && !m_full) m_wr++;
      m_lvl  = (((m_wr - rd_pos) % 32) + 32) % 32;
      m_full = (m_lvl == 16);
    end
  end

  always @(negedge wrclk) begin
    if (checking) begin
      checkOutput("cyc_wrptr",  int'(bus.wrptr),          int'(gray(m_wr % 32)));
      checkOutput("cyc_wraddr", int'(bus.wraddr),         m_wr % 16);
      checkOutput("cyc_memen",  int'(bus.wr_mem_en),      int'(bus.wr_en && !m_full));
      checkOutput("cyc_full",   int'(bus.wrfull),         int'(m_full));
      checkOutput("cyc_afull",  int'(bus.wr_almost_full), int'(m_lvl >= TH));
      checkOutput("cyc_level",  int'(bus.wr_level),       m_lvl);
      checkOutput("cyc_ovf",    int'(bus.wr_overflow),    int'(m_ovf));
    end
  end

  initial begin
    logic [A:0] prev_ptr;
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0; bus.wrq2_rdptr = '0;
    repeat (2) @(posedge wrclk);
    #2;
    checking = 1'b1;

    // Reset held while the producer toggles wr_en.
    for (int i = 0; i < 4; i++) applyStimulus(i[0], 1'b0, 0);
    checkOutput("rst_wrptr",  int'(bus.wrptr), 0);
    checkOutput("rst_full",   int'(bus.wrfull), 0);
    checkOutput("rst_level",  int'(bus.wr_level), 0);
    checkOutput("rst_ovf",    int'(bus.wr_overflow), 0);
    checkOutput("rst_wraddr", int'(bus.wraddr), 0);
    reset_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      checkOutput("fill_wraddr", int'(bus.wraddr), i - 1);
      applyStimulus(1'b1, 1'b0, 0);
      if (i == 11) checkOutput("fill_afull_11", int'(bus.wr_almost_full), 0);
      if (i == 12) checkOutput("fill_afull_12", int'(bus.wr_almost_full), 1);
      if (i == 15) checkOutput("fill_full_15", int'(bus.wrfull), 0);
    end
    checkOutput("fill_full_16",  int'(bus.wrfull), 1);
    checkOutput("fill_level_16", int'(bus.wr_level), 16);
    checkOutput("fill_wrptr_16", int'(bus.wrptr), 'b11000);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0);
    checkOutput("ovf_memen", int'(bus.wr_mem_en), 0);
    checkOutput("ovf_wrptr", int'(bus.wrptr), 'b11000);
    checkOutput("ovf_set",   int'(bus.wr_overflow), 1);
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("ovf_clear", int'(bus.wr_overflow), 0);
    applyStimulus(1'b1, 1'b1, 0);
    checkOutput("ovf_set_beats_clr", int'(bus.wr_overflow), 1);
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 0);

    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("drain_full",   int'(bus.wrfull), 0);
    checkOutput("drain_level4", int'(bus.wr_level), 12);
    checkOutput("drain_afull4", int'(bus.wr_almost_full), 1);
    applyStimulus(1'b0, 1'b0, 5);
    checkOutput("drain_level5", int'(bus.wr_level), 11);
    checkOutput("drain_afull5", int'(bus.wr_almost_full), 0);

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      prev_ptr = bus.wrptr;
      applyStimulus(1'b1, 1'b0, (i >= 2) ? i - 2 : 0);
      checkOutput("wrap_hamming", $countones(prev_ptr ^ bus.wrptr), 1);
      checkOutput("wrap_level_le3", int'(bus.wr_level <= 3), 1);
      checkOutput("wrap_nofull", int'(bus.wrfull), 0);
    end
    checkOutput("wrap_wraddr", int'(bus.wraddr), 8);
    checkOutput("wrap_wrptr",  int'(bus.wrptr), 'b01100);

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 0);
    bus.wr_en = 1'b0;
    checkOutput("async_pre_level", int'(bus.wr_level), 7);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_wrptr",  int'(bus.wrptr), 0);
    checkOutput("async_level",  int'(bus.wr_level), 0);
    checkOutput("async_full",   int'(bus.wrfull), 0);
    checkOutput("async_afull",  int'(bus.wr_almost_full), 0);
    checkOutput("async_ovf",    int'(bus.wr_overflow), 0);
    checkOutput("async_wraddr", int'(bus.wraddr), 0);
    @(posedge wrclk);
    #2 reset_n = 1'b1;
    bus.wr_en = 1'b1;
    #1;
    checkOutput("post_memen",  int'(bus.wr_mem_en), 1);
    checkOutput("post_wraddr", int'(bus.wraddr), 0);
    @(posedge wrclk);
    #2;
    checkOutput("post_wraddr1", int'(bus.wraddr), 1);
    checkOutput("post_level1",  int'(bus.wr_level), 1);
    applyStimulus(1'b0, 1'b0, 0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
